muxn_pipe: RTL and testbench
============================

Name: muxn_pipe

Overview:
- Parametrised N:1 word multiplexor with an optional pipeline register on its output.
- The register stage supports stall (hold), flush (bubble insertion), a valid bit, a registered copy of the select, and a sticky out-of-range select error.
- Used as the forwarding/operand-select stage between pipeline registers of the CPU datapath. It replaces chains of 2:1 muxes followed by a separate flop stage.

Parameters:
- WIDTH, 64, data width of each channel in bits.
- N, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N) (minimum 1), width of the select port. Derived, not overridden.
- REGISTERED, 1, 1 = output registered (latency 1); 0 = out/out_valid combinational (latency 0), err still registered.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  binary channel select
- in_valid  input  1  in/sel carry a real operation this cycle
- stall  input  1  hold the output register
- flush  input  1  replace the output register contents with a bubble
- out  output  WIDTH  selected data
- out_valid  output  1  out holds a valid operation
- out_sel  output  SEL_W  select value that produced out
- err  output  1  sticky: a valid operation used sel >= N

Behaviour:
- Reset (reset_n low, asynchronous, any time): out=0, out_valid=0, out_sel=0, err=0.
  - Reset asserted mid-stall or mid-flush discards everything.
  - First capture occurs on the first rising clk after reset_n goes high.
- Combinational select: sel_ok = (sel < N); mux_d = in[sel] if sel_ok, else all-zero. X-free for any sel value.
- REGISTERED=1, at each rising clk, in priority order:
  1. flush=1: out<=0, out_valid<=0, out_sel<=0. Flush beats stall when both are high.
  2. stall=1: out, out_valid and out_sel hold their values. Inputs are ignored and err is not updated.
  3. otherwise: out<=mux_d, out_valid<=in_valid & sel_ok, out_sel<=sel.
- Latency is 1 cycle from in/sel/in_valid to out/out_valid.
- in_valid=0 with no stall or flush still loads mux_d into out (don't-care data) with out_valid=0.
- REGISTERED=0:
  - out=mux_d, out_valid=in_valid & sel_ok, out_sel=sel, all combinational.
  - stall and flush affect only err sampling.
- err: at a rising clk with no flush and no stall, err<=err | (in_valid & ~sel_ok).
  - Cleared only by reset.
  - When N is a power of two, err is constant 0.
- Width rules: no arithmetic. sel is zero-extended for the sel < N compare.

Decomposition:
- Package mux_pkg:
  - function sel_width(n) returning max(1, clog2(n));
  - constant MUX_MAX_N = 16;
  - typedef for the flattened channel bus is not used, because WIDTH is per-instance.
- One sub-module, muxn_comb: purely combinational N:1 select plus range check.
  - Built as a log2 tree of the existing mux2 cell.
  - Out-of-range select is forced to zero with an AND stage.
- muxn_pipe wraps muxn_comb with the register, stall/flush priority and err logic.

Test Plan:
- Reset: assert reset_n=0 between clock edges with out previously 64'hDEAD -> out=0, out_valid=0, out_sel=0, err=0 immediately, before the next clk edge.
- Sweep: N=4, in[k]=64'h1111_0000+k, in_valid=1, sel=0..3 on successive cycles -> one cycle later out=64'h1111_0000..64'h1111_0003, out_valid=1, out_sel tracks sel.
- Stall: load sel=2, then stall=1 for 3 cycles while sel=1 and in changes -> out stays 64'h1111_0002, out_valid=1. Release -> next cycle out=in[1].
- Flush vs stall: stall=1 and flush=1 in the same cycle with out_valid=1 -> next cycle out=0, out_valid=0. Then normal load resumes.
- Range error: N=5, sel=7, in_valid=1 -> next cycle out=0, out_valid=0, err=1. err stays 1 after valid selects; cleared only by reset_n. The same sel=7 with in_valid=0 or stall=1 leaves err=0.
- REGISTERED=0: sel change from 0 to 3 -> out follows in[3] in the same cycle with no clk edge. out_valid = in_valid.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 word multiplexor family.
package mux_pkg;

  // Largest channel count the mux tree is intended for.
  localparam int unsigned MUX_MAX_N = 16;

  // Select width for n channels. It is at least 1 so that the port never
  // collapses to zero bits.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux2.sv
// mux2: word-wide 2:1 select cell.
//   a, b : data inputs (a when s=0, b when s=1)
//   s    : select
//   y_c  : selected word (combinational)
module mux2 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y_c
);

  assign y_c = s ? b : a;

endmodule

// File: rtl/muxn_comb.sv
// muxn_comb: combinational N:1 word select with a select range check.
//   in_flat  : N channels, channel k at [k*WIDTH +: WIDTH]
//   sel      : binary channel select
//   mux_c    : selected channel, forced to zero when sel >= N
//   sel_ok_c : sel addresses an existing channel
module muxn_comb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   mux_c,
  output logic               sel_ok_c
);

  localparam int unsigned LEAVES = 1 << SEL_W;
  localparam int unsigned CMP_W  = SEL_W + 1;

  // Heap-ordered tree: node 1 is the root, leaves sit at LEAVES..2*LEAVES-1.
  logic [WIDTH-1:0] node [1:2*LEAVES-1];

  // Leaves past the last real channel are tied to zero so an out-of-range
  // select can never propagate X.
  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N) begin : g_real
      assign node[LEAVES+i] = in_flat[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign node[LEAVES+i] = '0;
    end
  end

  // A node at depth d decides on sel bit (SEL_W-1-d), so the root uses the MSB.
  for (genvar j = 1; j < LEAVES; j++) begin : g_node
    localparam int unsigned DEPTH = $clog2(j + 1) - 1;
    mux2 #(.WIDTH(WIDTH)) u_mux2 (
      .a   (node[2*j]),
      .b   (node[2*j+1]),
      .s   (sel[SEL_W-1-DEPTH]),
      .y_c (node[j])
    );
  end

  // Zero-extended compare so N == 2**SEL_W is representable.
  assign sel_ok_c = ({1'b0, sel} < CMP_W'(N));
  assign mux_c    = node[1] & {WIDTH{sel_ok_c}};

endmodule

// File: rtl/muxn_pipe.sv
// muxn_pipe: N:1 word multiplexor with optional output register stage.
//   clk, reset_n : clock, asynchronous active-low reset
//   in           : N flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel          : binary channel select
//   in_valid     : in/sel carry a real operation
//   stall        : hold the output register (and err)
//   flush        : load a bubble into the output register (beats stall)
//   out          : selected data
//   out_valid    : out holds a valid operation
//   out_sel      : select value that produced out
//   err          : sticky, a valid operation used sel >= N
module muxn_pipe
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH      = 64,
  parameter  int unsigned N          = 4,
  parameter  int unsigned REGISTERED = 1,
  localparam int unsigned SEL_W      = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   out_sel,
  output logic               err
);

  logic [WIDTH-1:0] mux_c;
  logic             sel_ok_c;

  muxn_comb #(.WIDTH(WIDTH), .N(N)) u_comb (
    .in_flat  (in),
    .sel      (sel),
    .mux_c    (mux_c),
    .sel_ok_c (sel_ok_c)
  );

  // Sticky range error, sampled only on cycles that actually advance.
  logic err_d, err_q;

  always_comb begin
    err_d = err_q;
    if (!flush && !stall) begin
      err_d = err_q | (in_valid & ~sel_ok_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  if (REGISTERED != 0) begin : g_reg
    logic [WIDTH-1:0] out_d, out_q;
    logic             out_valid_d, out_valid_q;
    logic [SEL_W-1:0] out_sel_d, out_sel_q;

    // Priority: flush, then stall, then load.
    always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
      if (flush) begin
        out_d       = '0;
        out_valid_d = 1'b0;
        out_sel_d   = '0;
      end else if (!stall) begin
        out_d       = mux_c;
        out_valid_d = in_valid & sel_ok_c;
        out_sel_d   = sel;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
        out_sel_q   <= '0;
      end else begin
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
        out_sel_q   <= out_sel_d;
      end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
  end else begin : g_comb
    assign out       = mux_c;
    assign out_valid = in_valid & sel_ok_c;
    assign out_sel   = sel;
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench for muxn_pipe: registered N=4, registered N=5 and
// combinational N=4 instances driven from vector tables and short sequences.
module tb_muxn_pipe;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic [3:0]   sel;
    logic         vld;
    logic         stl;
    logic         fls;
    logic         scr;   // use the alternate input pattern this cycle
    logic [W-1:0] eo;
    logic         ev;
    logic [3:0]   es;
    logic         ee;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Registered, N=4
  logic [4*W-1:0] in4;
  logic [1:0]     sel4, os4;
  logic           vld4, stl4, fls4, ov4, err4;
  logic [W-1:0]   out4;
  // Registered, N=5
  logic [5*W-1:0] in5;
  logic [2:0]     sel5, os5;
  logic           vld5, stl5, fls5, ov5, err5;
  logic [W-1:0]   out5;
  // Combinational, N=4
  logic [4*W-1:0] inc;
  logic [1:0]     selc, osc;
  logic           vldc, stlc, flsc, ovc, errc;
  logic [W-1:0]   outc;

  muxn_pipe #(.WIDTH(W), .N(4), .REGISTERED(1)) u_r4 (
    .clk(clk), .reset_n(rst_n), .in(in4), .sel(sel4), .in_valid(vld4),
    .stall(stl4), .flush(fls4), .out(out4), .out_valid(ov4), .out_sel(os4), .err(err4));

  muxn_pipe #(.WIDTH(W), .N(5), .REGISTERED(1)) u_r5 (
    .clk(clk), .reset_n(rst_n), .in(in5), .sel(sel5), .in_valid(vld5),
    .stall(stl5), .flush(fls5), .out(out5), .out_valid(ov5), .out_sel(os5), .err(err5));

  muxn_pipe #(.WIDTH(W), .N(4), .REGISTERED(0)) u_c4 (
    .clk(clk), .reset_n(rst_n), .in(inc), .sel(selc), .in_valid(vldc),
    .stall(stlc), .flush(flsc), .out(outc), .out_valid(ovc), .out_sel(osc), .err(errc));

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];
  vec_t t4[$];
  vec_t t5[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5*W-1:0] mk_in(input logic [W-1:0] base);
    logic [5*W-1:0] r;
    for (int k = 0; k < 5; k++) r[k*W +: W] = base + W'(k);
    return r;
  endfunction

  function automatic vec_t mk(input int sel, input bit vld, input bit stl, input bit fls,
                              input bit scr, input logic [W-1:0] eo, input bit ev,
                              input int es, input bit ee);
    vec_t v;
    v.sel = 4'(sel); v.vld = vld; v.stl = stl; v.fls = fls; v.scr = scr;
    v.eo = eo; v.ev = ev; v.es = 4'(es); v.ee = ee;
    return v;
  endfunction

  // Drive one vector before the edge, score the registered result after it.
  task automatic apply(input bit five, input vec_t v);
    logic [5*W-1:0] tmp;
    vec_t e;
    @(negedge clk);
    tmp = mk_in(v.scr ? 64'hAAAA_0000 : 64'h1111_0000);
    if (five) begin
      in5 = tmp; sel5 = v.sel[2:0]; vld5 = v.vld; stl5 = v.stl; fls5 = v.fls;
    end else begin
      in4 = tmp[4*W-1:0]; sel4 = v.sel[1:0]; vld4 = v.vld; stl4 = v.stl; fls4 = v.fls;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (five) begin
      check("r5_out", out5, e.eo);
      check("r5_valid", W'(ov5), W'(e.ev));
      check("r5_sel", W'(os5), W'(e.es));
      check("r5_err", W'(err5), W'(e.ee));
    end else begin
      check("r4_out", out4, e.eo);
      check("r4_valid", W'(ov4), W'(e.ev));
      check("r4_sel", W'(os4), W'(e.es));
      check("r4_err", W'(err4), W'(e.ee));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5*W-1:0] tmp;
    rst_n = 1'b0;
    in4 = '0; sel4 = '0; vld4 = 0; stl4 = 0; fls4 = 0;
    in5 = '0; sel5 = '0; vld5 = 0; stl5 = 0; fls5 = 0;
    inc = '0; selc = '0; vldc = 0; stlc = 0; flsc = 0;

    //        sel vld stl fls scr  out            vld sel err
    t4.push_back(mk(0, 1, 0, 0, 0, 64'h1111_0000, 1, 0, 0));
    t4.push_back(mk(1, 1, 0, 0, 0, 64'h1111_0001, 1, 1, 0));
    t4.push_back(mk(2, 1, 0, 0, 0, 64'h1111_0002, 1, 2, 0));
    t4.push_back(mk(3, 1, 0, 0, 0, 64'h1111_0003, 1, 3, 0));
    t4.push_back(mk(2, 1, 0, 0, 0, 64'h1111_0002, 1, 2, 0));
    t4.push_back(mk(1, 1, 1, 0, 1, 64'h1111_0002, 1, 2, 0));
    t4.push_back(mk(1, 1, 1, 0, 1, 64'h1111_0002, 1, 2, 0));
    t4.push_back(mk(1, 1, 1, 0, 1, 64'h1111_0002, 1, 2, 0));
    t4.push_back(mk(1, 1, 0, 0, 0, 64'h1111_0001, 1, 1, 0));
    t4.push_back(mk(3, 1, 1, 1, 0, 64'h0,         0, 0, 0));
    t4.push_back(mk(3, 1, 0, 0, 0, 64'h1111_0003, 1, 3, 0));
    t4.push_back(mk(0, 0, 0, 0, 0, 64'h1111_0000, 0, 0, 0));
    t4.push_back(mk(2, 1, 0, 1, 0, 64'h0,         0, 0, 0));
    t4.push_back(mk(1, 0, 1, 0, 0, 64'h0,         0, 0, 0));
    t4.push_back(mk(1, 1, 0, 0, 0, 64'h1111_0001, 1, 1, 0));

    t5.push_back(mk(7, 0, 0, 0, 0, 64'h0,         0, 7, 0));
    t5.push_back(mk(7, 1, 1, 0, 0, 64'h0,         0, 7, 0));
    t5.push_back(mk(7, 1, 0, 1, 0, 64'h0,         0, 0, 0));
    t5.push_back(mk(4, 1, 0, 0, 0, 64'h1111_0004, 1, 4, 0));
    t5.push_back(mk(7, 1, 0, 0, 0, 64'h0,         0, 7, 1));
    t5.push_back(mk(5, 1, 0, 0, 0, 64'h0,         0, 5, 1));
    t5.push_back(mk(0, 1, 0, 0, 0, 64'h1111_0000, 1, 0, 1));
    t5.push_back(mk(3, 1, 1, 1, 0, 64'h0,         0, 0, 1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_r4_out", out4, '0);
    check("rst_r4_valid", W'(ov4), '0);
    check("rst_r5_sel", W'(os5), '0);
    check("rst_r5_err", W'(err5), '0);
    check("rst_c4_out", outc, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (t4[i]) apply(1'b0, t4[i]);
    foreach (t5[i]) apply(1'b1, t5[i]);

    // Asynchronous reset mid-stall, between clock edges
    @(negedge clk);
    tmp = '0;
    tmp[W-1:0] = 64'hDEAD;
    in4 = tmp[4*W-1:0]; sel4 = 2'd0; vld4 = 1'b1; stl4 = 1'b0; fls4 = 1'b0;
    sel5 = 3'd0; stl5 = 1'b0; fls5 = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_out", out4, 64'hDEAD);
    stl4 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out4, '0);
    check("async_rst_valid", W'(ov4), '0);
    check("async_rst_err5", W'(err5), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_stall_out", out4, '0);
    @(negedge clk);
    stl4 = 1'b0;
    @(posedge clk);
    #1;
    check("first_capture_out", out4, 64'hDEAD);
    check("first_capture_valid", W'(ov4), 64'd1);

    // Combinational variant: changes settle with no clock edge in between
    @(negedge clk);
    tmp = mk_in(64'h2222_0000);
    inc = tmp[4*W-1:0]; selc = 2'd0; vldc = 1'b1;
    #1;
    check("c4_out_sel0", outc, 64'h2222_0000);
    check("c4_valid", W'(ovc), 64'd1);
    selc = 2'd3;
    #1;
    check("c4_out_sel3", outc, 64'h2222_0003);
    check("c4_outsel", W'(osc), 64'd3);
    vldc = 1'b0;
    #1;
    check("c4_valid_low", W'(ovc), '0);
    flsc = 1'b1;
    #1;
    check("c4_flush_noeffect", outc, 64'h2222_0003);
    check("c4_err", W'(errc), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
